mr_control_unit: RTL and testbench

- Control unit for the rudimentary machine datapath.
- Sequences load enables of PC, IR, address register (R@), register file and flag register, plus memory write and the datapath mux selects, through fetch/decode/execute.
- Sits between the instruction register fields/flags and the `register`-based datapath.
- Every datapath register load in the CPU is driven by this block.

---
 rtl/mr_control_unit_if.sv | 37 +++
 rtl/mr_control_unit.sv | 148 ++++++++++++++
 tb/tb_mr_control_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mr_control_unit_if.sv
// Control-unit bus: IR fields, flags and run in; load enables, selects and status out.
// master = datapath/IR side, slave = control unit.
interface mr_control_unit_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [1:0]       ir_op;
    logic [2:0]       ir_cond;
    logic [2:0]       ir_fn;
    logic             flag_z;
    logic             flag_n;

    logic             ld_pc;
    logic             ld_ir;
    logic             ld_ra;
    logic             ld_rf;
    logic             ld_flags;
    logic             mem_we;
    logic             sel_addr;
    logic             sel_pc;
    logic             sel_rf_in;
    logic             busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output run, ir_op, ir_cond, ir_fn, flag_z, flag_n,
        input  ld_pc, ld_ir, ld_ra, ld_rf, ld_flags, mem_we,
               sel_addr, sel_pc, sel_rf_in, busy, state, instr_cnt
    );

    modport slave (
        input  run, ir_op, ir_cond, ir_fn, flag_z, flag_n,
        output ld_pc, ld_ir, ld_ra, ld_rf, ld_flags, mem_we,
               sel_addr, sel_pc, sel_rf_in, busy, state, instr_cnt
    );
endinterface

// File: rtl/mr_control_unit.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction; run only starts work and never aborts it.
// Optional MR_CU_SINGLE_STEP_EN adds step_mode: one instruction per run rising edge.
module mr_control_unit #(
    parameter int         CNT_W  = 16,
    parameter logic [2:0] CMP_FN = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MR_CU_SINGLE_STEP_EN
    input  logic             step_mode,
`endif
    mr_control_unit_if.slave cu
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LOAD   = 3'd3,
        S_STORE  = 3'd4,
        S_BRANCH = 3'd5,
        S_ALU    = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             exec_exit;
    logic             br_take;
    logic             start_ok;
    logic             cont_ok;

`ifdef MR_CU_SINGLE_STEP_EN
    logic run_q;

    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= cu.run;
    end

    // In step mode a held run must not retrigger: only its rising edge starts work.
    assign start_ok = step_mode ? (cu.run && !run_q) : cu.run;
    assign cont_ok  = !step_mode && cu.run;
`else
    assign start_ok = cu.run;
    assign cont_ok  = cu.run;
`endif

    always_comb begin
        br_take = 1'b0;
        case (cu.ir_cond)
            3'b000:  br_take = 1'b1;
            3'b001:  br_take = cu.flag_z;
            3'b010:  br_take = cu.flag_n;
            3'b011:  br_take = cu.flag_n | cu.flag_z;
            3'b100:  br_take = 1'b0;
            3'b101:  br_take = !cu.flag_z;
            3'b110:  br_take = !cu.flag_n;
            default: br_take = !cu.flag_n & !cu.flag_z;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        exec_exit    = 1'b0;
        cu.ld_pc     = 1'b0;
        cu.ld_ir     = 1'b0;
        cu.ld_ra     = 1'b0;
        cu.ld_rf     = 1'b0;
        cu.ld_flags  = 1'b0;
        cu.mem_we    = 1'b0;
        cu.sel_addr  = 1'b0;
        cu.sel_pc    = 1'b0;
        cu.sel_rf_in = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_FETCH;
            end
            S_FETCH: begin
                cu.ld_ir = 1'b1;
                cu.ld_pc = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                cu.ld_ra = 1'b1;
                case (cu.ir_op)
                    2'b00:   state_d = S_LOAD;
                    2'b01:   state_d = S_STORE;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_ALU;
                endcase
            end
            S_LOAD: begin
                cu.sel_addr  = 1'b1;
                cu.sel_rf_in = 1'b1;
                cu.ld_rf     = 1'b1;
                cu.ld_flags  = 1'b1;
                exec_exit    = 1'b1;
            end
            S_STORE: begin
                cu.sel_addr = 1'b1;
                cu.mem_we   = 1'b1;
                exec_exit   = 1'b1;
            end
            S_BRANCH: begin
                cu.ld_pc  = br_take;
                cu.sel_pc = br_take;
                exec_exit = 1'b1;
            end
            S_ALU: begin
                cu.ld_flags = 1'b1;
                cu.ld_rf    = (cu.ir_fn != CMP_FN);
                exec_exit   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (exec_exit) state_d = cont_ok ? S_FETCH : S_IDLE;

        // A reset edge must not commit any side effect of the cycle it lands in.
        if (rst) begin
            cu.ld_pc     = 1'b0;
            cu.ld_ir     = 1'b0;
            cu.ld_ra     = 1'b0;
            cu.ld_rf     = 1'b0;
            cu.ld_flags  = 1'b0;
            cu.mem_we    = 1'b0;
            cu.sel_addr  = 1'b0;
            cu.sel_pc    = 1'b0;
            cu.sel_rf_in = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (exec_exit) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cu.busy      = (state_q != S_IDLE);
    assign cu.state     = state_q;
    assign cu.instr_cnt = cnt_q;

endmodule

// File: tb/tb_mr_control_unit.sv
// Bench for mr_control_unit: directed vector table, branch matrix and random run against an instruction-level model.
module tb_mr_control_unit;
    localparam int CNT_W = 16;

    // ctrl bit order: {ld_pc, ld_ir, ld_ra, ld_rf, ld_flags, mem_we, sel_addr, sel_pc, sel_rf_in}
    localparam logic [8:0] C_NONE   = 9'b000_000_000;
    localparam logic [8:0] C_FETCH  = 9'b110_000_000;
    localparam logic [8:0] C_DECODE = 9'b001_000_000;
    localparam logic [8:0] C_LOAD   = 9'b000_110_101;
    localparam logic [8:0] C_STORE  = 9'b000_001_100;
    localparam logic [8:0] C_BR     = 9'b100_000_010;
    localparam logic [8:0] C_ALU    = 9'b000_110_000;
    localparam logic [8:0] C_CMP    = 9'b000_010_000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mr_control_unit_if #(.CNT_W(CNT_W)) bus ();

`ifdef MR_CU_SINGLE_STEP_EN
    logic step_mode = 1'b0;
`endif

    mr_control_unit #(.CNT_W(CNT_W), .CMP_FN(3'b111)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MR_CU_SINGLE_STEP_EN
        .step_mode (step_mode),
`endif
        .cu        (bus)
    );

    logic [8:0] act_ctrl;
    assign act_ctrl = {bus.ld_pc, bus.ld_ir, bus.ld_ra, bus.ld_rf, bus.ld_flags,
                       bus.mem_we, bus.sel_addr, bus.sel_pc, bus.sel_rf_in};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: idle, or step 0/1/2 of the current instruction.
    bit          m_idle = 1'b1;
    int          m_step = 0;
    logic [1:0]  m_op   = 2'b00;
    logic [15:0] m_cnt  = '0;
    bit          m_run_q = 1'b0;

    function automatic logic cond_true(input logic [2:0] c, input logic z, input logic n);
        logic base;
        case (c[1:0])
            2'd0:    base = 1'b1;
            2'd1:    base = z;
            2'd2:    base = n;
            default: base = n | z;
        endcase
        return c[2] ? !base : base;
    endfunction

    function automatic logic [8:0] model_ctrl();
        if (rst || m_idle) return C_NONE;
        if (m_step == 0) return C_FETCH;
        if (m_step == 1) return C_DECODE;
        case (m_op)
            2'd0:    return C_LOAD;
            2'd1:    return C_STORE;
            2'd2:    return cond_true(bus.ir_cond, bus.flag_z, bus.flag_n) ? C_BR : C_NONE;
            default: return (bus.ir_fn == 3'b111) ? C_CMP : C_ALU;
        endcase
    endfunction

    function automatic logic [2:0] model_state();
        if (m_idle) return 3'd0;
        if (m_step < 2) return 3'(m_step + 1);
        return 3'(3 + int'(m_op));
    endfunction

    task automatic model_update();
        bit start_ok, cont_ok;
        start_ok = bus.run;
        cont_ok  = bus.run;
`ifdef MR_CU_SINGLE_STEP_EN
        if (step_mode) begin
            start_ok = bus.run && !m_run_q;
            cont_ok  = 1'b0;
        end
`endif
        if (rst) begin
            m_idle  = 1'b1;
            m_step  = 0;
            m_cnt   = '0;
            m_run_q = 1'b0;
        end else begin
            if (m_idle) begin
                if (start_ok) begin
                    m_idle = 1'b0;
                    m_step = 0;
                end
            end else if (m_step == 0) begin
                m_step = 1;
            end else if (m_step == 1) begin
                m_step = 2;
                m_op   = bus.ir_op;
            end else begin
                m_cnt = m_cnt + 16'd1;
                if (cont_ok) m_step = 0;
                else         m_idle = 1'b1;
            end
            m_run_q = bus.run;
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1 ns later.
    task automatic model_cycle(input string tag);
        #1;
        chk({tag, " state"}, 32'(bus.state), 32'(model_state()));
        chk({tag, " ctrl"},  32'(act_ctrl),  32'(model_ctrl()));
        chk({tag, " busy"},  32'(bus.busy),  32'(!m_idle));
        chk({tag, " cnt"},   32'(bus.instr_cnt), 32'(m_cnt));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic rn, input logic [1:0] op, input logic [2:0] cond,
                          input logic [2:0] fn, input logic z, input logic n);
        rst = r; bus.run = rn; bus.ir_op = op; bus.ir_cond = cond;
        bus.ir_fn = fn; bus.flag_z = z; bus.flag_n = n;
    endtask

    typedef struct {
        logic       rst;
        logic       run;
        logic [1:0] op;
        logic [2:0] cond;
        logic [2:0] fn;
        logic       z;
        logic       n;
        logic [2:0] st;
        logic [8:0] ctrl;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic rn, input logic [1:0] op, input logic [2:0] cond,
                               input logic [2:0] fn, input logic [2:0] st, input logic [8:0] ctrl,
                               input logic [15:0] cnt);
        vec_t x;
        x.rst = r; x.run = rn; x.op = op; x.cond = cond; x.fn = fn;
        x.z = 1'b0; x.n = 1'b0; x.st = st; x.ctrl = ctrl; x.cnt = cnt;
        return x;
    endfunction

    initial begin
        //                r  run op     cond    fn      st    ctrl      cnt
        tbl.push_back(v(1, 1, 2'd0, 3'd0, 3'd0, 3'd0, C_NONE,   16'd0));
        tbl.push_back(v(1, 1, 2'd0, 3'd0, 3'd0, 3'd0, C_NONE,   16'd0));
        tbl.push_back(v(0, 1, 2'd0, 3'd0, 3'd0, 3'd0, C_NONE,   16'd0));
        tbl.push_back(v(0, 1, 2'd0, 3'd0, 3'd0, 3'd1, C_FETCH,  16'd0));
        tbl.push_back(v(0, 1, 2'd0, 3'd0, 3'd0, 3'd2, C_DECODE, 16'd0));
        tbl.push_back(v(0, 1, 2'd0, 3'd0, 3'd0, 3'd3, C_LOAD,   16'd0));
        tbl.push_back(v(0, 1, 2'd1, 3'd0, 3'd0, 3'd1, C_FETCH,  16'd1));
        tbl.push_back(v(0, 1, 2'd1, 3'd0, 3'd0, 3'd2, C_DECODE, 16'd1));
        tbl.push_back(v(0, 1, 2'd1, 3'd0, 3'd0, 3'd4, C_STORE,  16'd1));
        tbl.push_back(v(0, 1, 2'd2, 3'd7, 3'd0, 3'd1, C_FETCH,  16'd2));
        tbl.push_back(v(0, 1, 2'd2, 3'd7, 3'd0, 3'd2, C_DECODE, 16'd2));
        tbl.push_back(v(0, 1, 2'd2, 3'd7, 3'd0, 3'd5, C_BR,     16'd2));
        tbl.push_back(v(0, 1, 2'd2, 3'd4, 3'd0, 3'd1, C_FETCH,  16'd3));
        tbl.push_back(v(0, 1, 2'd2, 3'd4, 3'd0, 3'd2, C_DECODE, 16'd3));
        tbl.push_back(v(0, 1, 2'd2, 3'd4, 3'd0, 3'd5, C_NONE,   16'd3));
        tbl.push_back(v(0, 1, 2'd3, 3'd0, 3'd0, 3'd1, C_FETCH,  16'd4));
        tbl.push_back(v(0, 1, 2'd3, 3'd0, 3'd0, 3'd2, C_DECODE, 16'd4));
        tbl.push_back(v(0, 1, 2'd3, 3'd0, 3'd0, 3'd6, C_ALU,    16'd4));
        tbl.push_back(v(0, 1, 2'd3, 3'd0, 3'd7, 3'd1, C_FETCH,  16'd5));
        tbl.push_back(v(0, 0, 2'd3, 3'd0, 3'd7, 3'd2, C_DECODE, 16'd5));
        tbl.push_back(v(0, 0, 2'd3, 3'd0, 3'd7, 3'd6, C_CMP,    16'd5));
        tbl.push_back(v(0, 0, 2'd1, 3'd0, 3'd0, 3'd0, C_NONE,   16'd6));
        tbl.push_back(v(0, 1, 2'd1, 3'd0, 3'd0, 3'd0, C_NONE,   16'd6));
        tbl.push_back(v(0, 1, 2'd1, 3'd0, 3'd0, 3'd1, C_FETCH,  16'd6));
        tbl.push_back(v(0, 1, 2'd1, 3'd0, 3'd0, 3'd2, C_DECODE, 16'd6));
        tbl.push_back(v(1, 1, 2'd1, 3'd0, 3'd0, 3'd4, C_NONE,   16'd6));
        tbl.push_back(v(0, 0, 2'd1, 3'd0, 3'd0, 3'd0, C_NONE,   16'd0));

        set_in(1, 1, 2'd0, 3'd0, 3'd0, 0, 0);
        @(posedge clk);
        model_update();
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rst, tbl[i].run, tbl[i].op, tbl[i].cond, tbl[i].fn, tbl[i].z, tbl[i].n);
            #1;
            chk($sformatf("vec%0d state", i), 32'(bus.state), 32'(tbl[i].st));
            chk($sformatf("vec%0d ctrl", i),  32'(act_ctrl),  32'(tbl[i].ctrl));
            chk($sformatf("vec%0d busy", i),  32'(bus.busy),  32'(tbl[i].st != 3'd0));
            chk($sformatf("vec%0d cnt", i),   32'(bus.instr_cnt), 32'(tbl[i].cnt));
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        // Branch matrix: every condition against flag pairs 00, 01, 10.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                logic zz, nn;
                zz = (k == 2);
                nn = (k == 1);
                set_in(0, 1, 2'd2, 3'(c), 3'd0, zz, nn);
                if (!m_idle || m_step != 0) ;
                for (int s = 0; s < 3; s++) model_cycle($sformatf("br c%0d k%0d", c, k));
                if (m_idle) model_cycle("br idle");
            end
        end
        bus.run = 1'b0;
        for (int s = 0; s < 4; s++) model_cycle("drain");

        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            model_cycle("rand");
        end

`ifdef MR_CU_SINGLE_STEP_EN
        step_mode = 1'b1;
        set_in(1, 0, 2'd1, 3'd0, 3'd0, 0, 0);
        model_cycle("step rst");
        rst = 1'b0;
        model_cycle("step idle");
        bus.run = 1'b1;
        for (int s = 0; s < 10; s++) model_cycle("step hold");
        chk("step hold state", 32'(bus.state), 32'd0);
        chk("step hold cnt", 32'(bus.instr_cnt), 32'd1);
        rst = 1'b1;
        bus.run = 1'b0;
        model_cycle("step rst2");
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            bus.run = 1'b0;
            for (int s = 0; s < 2; s++) model_cycle("pulse low");
            bus.run = 1'b1;
            for (int s = 0; s < 5; s++) model_cycle("pulse high");
        end
        chk("step pulses cnt", 32'(bus.instr_cnt), 32'd3);
        chk("step pulses state", 32'(bus.state), 32'd0);
        step_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
